// File: rtl/sram_ctrl_if.sv
// ============================================================================
// Module   : sram_ctrl_if
// Brief    : Request/response port and SRAM pad bundle used by sram_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sram_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              sram_cs_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_in;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, sram_dq_in,
        output req_ready, rsp_valid, rsp_rdata,
        output sram_cs_n, sram_oe_n, sram_we_n, sram_addr, sram_dq_out, sram_dq_oe
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, sram_dq_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  sram_cs_n, sram_oe_n, sram_we_n, sram_addr, sram_dq_out, sram_dq_oe
    );
endinterface

`default_nettype wire

// File: rtl/sram_ctrl.sv
// ============================================================================
// Module   : sram_ctrl
// Brief    : Async SRAM controller with registered strobes (setup/access/recover).
//            Optional one-entry request buffer: define SRAM_CTRL_REQ_BUF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    sram_ctrl_if.slave bus
);
    localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_EFF - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_ACCESS  = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_we_q, op_we_d;
    logic              cs_n_q, cs_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              w_accept;
    logic              w_start;
    logic              w_start_we;
    logic [ADDR_W-1:0] w_start_addr;
    logic [DATA_W-1:0] w_start_wdata;

`ifdef SRAM_CTRL_REQ_BUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;

    assign bus.req_ready = (state_q == ST_IDLE) || !buf_valid_q;
`else
    assign bus.req_ready = (state_q == ST_IDLE);
`endif

    assign w_accept = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_we_d       = op_we_q;
        cs_n_d        = cs_n_q;
        oe_n_d        = oe_n_q;
        we_n_d        = we_n_q;
        addr_d        = addr_q;
        dq_out_d      = dq_out_q;
        dq_oe_d       = dq_oe_q;
        rsp_valid_d   = 1'b0;
        rdata_d       = rdata_q;
        w_start       = 1'b0;
        w_start_we    = bus.req_we;
        w_start_addr  = bus.req_addr;
        w_start_wdata = bus.req_wdata;
`ifdef SRAM_CTRL_REQ_BUF_EN
        buf_valid_d   = buf_valid_q;
        buf_we_d      = buf_we_q;
        buf_addr_d    = buf_addr_q;
        buf_wdata_d   = buf_wdata_q;
`endif

        case (state_q)
            ST_IDLE: begin
                w_start = w_accept;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
                if (op_we_q) begin
                    we_n_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RECOVER;
                    rsp_valid_d = 1'b1;
                    if (op_we_q) begin
                        // CS and DQ stay driven through RECOVER for data hold after WE rises
                        we_n_d = 1'b1;
                    end else begin
                        rdata_d = bus.sram_dq_in;
                        cs_n_d  = 1'b1;
                        oe_n_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
`ifdef SRAM_CTRL_REQ_BUF_EN
                if (buf_valid_q) begin
                    w_start       = 1'b1;
                    w_start_we    = buf_we_q;
                    w_start_addr  = buf_addr_q;
                    w_start_wdata = buf_wdata_q;
                    buf_valid_d   = 1'b0;
                end else begin
                    w_start = w_accept;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef SRAM_CTRL_REQ_BUF_EN
        // RECOVER hands a fresh request straight to SETUP, so only park it mid-access
        if (w_accept && (state_q == ST_SETUP || state_q == ST_ACCESS)) begin
            buf_valid_d = 1'b1;
            buf_we_d    = bus.req_we;
            buf_addr_d  = bus.req_addr;
            buf_wdata_d = bus.req_wdata;
        end
`endif

        if (w_start) begin
            state_d = ST_SETUP;
            op_we_d = w_start_we;
            addr_d  = w_start_addr;
            cs_n_d  = 1'b0;
            we_n_d  = 1'b1;
            if (w_start_we) begin
                oe_n_d   = 1'b1;
                dq_oe_d  = 1'b1;
                dq_out_d = w_start_wdata;
            end else begin
                oe_n_d  = 1'b0;
                dq_oe_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_we_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            addr_q      <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
`ifdef SRAM_CTRL_REQ_BUF_EN
            buf_valid_q <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_we_q     <= op_we_d;
            cs_n_q      <= cs_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            addr_q      <= addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
`ifdef SRAM_CTRL_REQ_BUF_EN
            buf_valid_q <= buf_valid_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
`endif
        end
    end

    assign bus.sram_cs_n   = cs_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;

endmodule

`default_nettype wire
